// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the load/store initiator and its lane packer.
package mem_access_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_STORE_WAIT,
    ST_STORE_RELEASE,
    ST_RESP
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] FAULT_NONE       = 2'd0;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT    = 2'd2;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_BYTE = 2'd1;
  localparam logic [1:0] MW_HALF = 2'd2;
  localparam logic [1:0] MW_WORD = 2'd3;

  // The reserved size code 3 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

  function automatic logic [1:0] size_to_mw(input logic [1:0] size);
    logic [1:0] mw;
    case (size)
      SIZE_BYTE: mw = MW_BYTE;
      SIZE_HALF: mw = MW_HALF;
      default:   mw = MW_WORD;
    endcase
    return mw;
  endfunction

endpackage

// File: rtl/mem_lane_pack.sv
// Store lane packing (d0 = most-significant lane) and load extraction/extension.
module mem_lane_pack
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_qword,
  output logic [31:0] o_lanes_c,
  output logic [31:0] o_rdata_c
);

  always_comb begin
    o_lanes_c = 32'h0;
    o_rdata_c = 32'h0;
    case (i_size)
      SIZE_BYTE: begin
        o_lanes_c = {i_wdata[7:0], 24'h0};
        o_rdata_c = {{24{i_signed & i_qword[31]}}, i_qword[31:24]};
      end
      SIZE_HALF: begin
        o_lanes_c = {i_wdata[15:0], 16'h0};
        o_rdata_c = {{16{i_signed & i_qword[31]}}, i_qword[31:16]};
      end
      default: begin
        o_lanes_c = i_wdata;
        o_rdata_c = i_qword;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator driving a byte_addressable responder.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned READ_WAIT = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_write,
  output logic [7:0]  mem_d0,
  output logic [7:0]  mem_d1,
  output logic [7:0]  mem_d2,
  output logic [7:0]  mem_d3,
  input  logic [7:0]  mem_q0,
  input  logic [7:0]  mem_q1,
  input  logic [7:0]  mem_q2,
  input  logic [7:0]  mem_q3,
  input  logic        mem_error,
  input  logic        mem_done
);

  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  state_e            r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [1:0]        r_size, w_nxt_size;
  logic              r_signed, w_nxt_signed;
  logic              r_req_ready, w_nxt_req_ready;
  logic              r_resp_valid, w_nxt_resp_valid;
  logic [31:0]       r_resp_rdata, w_nxt_resp_rdata;
  logic [1:0]        r_resp_fault, w_nxt_resp_fault;
  logic [31:0]       r_hold_rdata, w_nxt_hold_rdata;
  logic [1:0]        r_hold_fault, w_nxt_hold_fault;
  logic [31:0]       r_mem_address, w_nxt_mem_address;
  logic [1:0]        r_mem_write, w_nxt_mem_write;
  logic [31:0]       r_lanes, w_nxt_lanes;

  logic [1:0]        w_req_size;
  logic [1:0]        w_pack_size;
  logic [31:0]       w_lanes_c;
  logic [31:0]       w_rdata_c;

  assign w_req_size  = norm_size(req_size);
  // In IDLE the packer serves the incoming store; afterwards it decodes the load.
  assign w_pack_size = (r_state == ST_IDLE) ? w_req_size : r_size;

  mem_lane_pack u_pack (
    .i_size    (w_pack_size),
    .i_signed  (r_signed),
    .i_wdata   (req_wdata),
    .i_qword   ({mem_q0, mem_q1, mem_q2, mem_q3}),
    .o_lanes_c (w_lanes_c),
    .o_rdata_c (w_rdata_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = r_cnt;
    w_nxt_size        = r_size;
    w_nxt_signed      = r_signed;
    w_nxt_req_ready   = r_req_ready;
    w_nxt_resp_valid  = 1'b0;
    w_nxt_resp_rdata  = 32'h0;
    w_nxt_resp_fault  = FAULT_NONE;
    w_nxt_hold_rdata  = r_hold_rdata;
    w_nxt_hold_fault  = r_hold_fault;
    w_nxt_mem_address = r_mem_address;
    w_nxt_mem_write   = r_mem_write;
    w_nxt_lanes       = r_lanes;

    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_nxt_req_ready  = 1'b0;
          w_nxt_size       = w_req_size;
          w_nxt_signed     = req_signed;
          w_nxt_cnt        = '0;
          w_nxt_hold_rdata = 32'h0;
          if (req_addr[1:0] != 2'b00) begin
            w_nxt_hold_fault = FAULT_MISALIGNED;
            w_nxt_state      = ST_RESP;
          end else begin
            w_nxt_hold_fault  = FAULT_NONE;
            w_nxt_mem_address = req_addr;
            if (req_store) begin
              w_nxt_mem_write = size_to_mw(w_req_size);
              w_nxt_lanes     = w_lanes_c;
              w_nxt_state     = ST_STORE_WAIT;
            end else begin
              w_nxt_lanes = 32'h0;
              w_nxt_state = ST_LOAD_WAIT;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (r_cnt == READ_LAST) begin
          w_nxt_state = ST_RESP;
          if (mem_error) begin
            w_nxt_hold_fault = FAULT_MISALIGNED;
            w_nxt_hold_rdata = 32'h0;
          end else begin
            w_nxt_hold_rdata = w_rdata_c;
          end
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_STORE_WAIT: begin
        if (mem_done) begin
          w_nxt_mem_write = MW_NONE;
          w_nxt_cnt       = '0;
          w_nxt_state     = ST_STORE_RELEASE;
        end else if (r_cnt == TMO_LAST) begin
          w_nxt_mem_write  = MW_NONE;
          w_nxt_hold_fault = FAULT_TIMEOUT;
          w_nxt_state      = ST_RESP;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_STORE_RELEASE: begin
        if (!mem_done) begin
          w_nxt_state = ST_RESP;
        end else if (r_cnt == TMO_LAST) begin
          w_nxt_hold_fault = FAULT_TIMEOUT;
          w_nxt_state      = ST_RESP;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_nxt_resp_valid = 1'b1;
        w_nxt_resp_rdata = r_hold_rdata;
        w_nxt_resp_fault = r_hold_fault;
        w_nxt_req_ready  = 1'b1;
        w_nxt_state      = ST_IDLE;
      end
      default: begin
        w_nxt_mem_write = MW_NONE;
        w_nxt_req_ready = 1'b1;
        w_nxt_state     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_size        <= SIZE_BYTE;
      r_signed      <= 1'b0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_resp_fault  <= FAULT_NONE;
      r_hold_rdata  <= 32'h0;
      r_hold_fault  <= FAULT_NONE;
      r_mem_address <= 32'h0;
      r_mem_write   <= MW_NONE;
      r_lanes       <= 32'h0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_size        <= w_nxt_size;
      r_signed      <= w_nxt_signed;
      r_req_ready   <= w_nxt_req_ready;
      r_resp_valid  <= w_nxt_resp_valid;
      r_resp_rdata  <= w_nxt_resp_rdata;
      r_resp_fault  <= w_nxt_resp_fault;
      r_hold_rdata  <= w_nxt_hold_rdata;
      r_hold_fault  <= w_nxt_hold_fault;
      r_mem_address <= w_nxt_mem_address;
      r_mem_write   <= w_nxt_mem_write;
      r_lanes       <= w_nxt_lanes;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_fault  = r_resp_fault;
  assign mem_address = r_mem_address;
  assign mem_write   = r_mem_write;
  assign mem_d0      = r_lanes[31:24];
  assign mem_d1      = r_lanes[23:16];
  assign mem_d2      = r_lanes[15:8];
  assign mem_d3      = r_lanes[7:0];

endmodule
